wm_cycle_controller: RTL and testbench
======================================

// Module: wm_cycle_controller
// PURPOSE
//  Parametrised washing-machine cycle controller. Coin-operated sequencer with per-phase down-counters,
//  lid-pause, rinse repetition, mode-dependent entry point, drain-on-cancel and change return.
//  Sits between the front-panel inputs and the motor/valve drivers; one instance per machine.
// PARAMETERS
//  TIMER_W        8   width of phase timer and remaining port
//  SOAK_CYCLES   16   soak phase length in clocks (1..2**TIMER_W)
//  WASH_CYCLES   32   wash phase length in clocks (1..2**TIMER_W)
//  RINSE_CYCLES  16   length of one rinse pass in clocks (1..2**TIMER_W)
//  SPIN_CYCLES    8   spin phase length in clocks (1..2**TIMER_W)
//  FILL_CYCLES    4   water_intake clocks at start of each soak/wash/rinse pass (1..min water phase)
//  RINSE_REPEATS  2   rinse passes for mode_1/mode_2 (>=1); mode_3 always does 1
// PORTS
//  clock            in   1        rising-edge clock
//  reset_n          in   1        async active-low reset
//  lid              in   1        1 = lid open
//  coin             in   1        coin inserted, 1-cycle level sample
//  cancel           in   1        user cancel
//  mode_1/2/3       in   1 each   program select; priority mode_1 > mode_2 > mode_3
//  idle, ready      out  1 each   state IDLE / READY
//  soak_operation, wash_operation, rinse_operation, spin_operation  out 1 each  current phase
//  water_intake     out  1        fill valve
//  coin_return      out  1        1-cycle refund pulse
//  paused           out  1        phase active but timer frozen by open lid
//  done             out  1        1-cycle pulse when a program completes normally
//  remaining        out  TIMER_W  clocks left in current phase minus 1; 0 in IDLE/READY
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, idle=1, all other outputs 0, remaining=0, rinse count=0.
//  State/phase outputs are a decode of registered state; they change 1 clock after the deciding edge.
//  coin_return and done are registered pulses, high exactly 1 clock.
//  IDLE: coin=1 -> READY. Otherwise hold.
//  READY: cancel=1 -> IDLE with coin_return pulse (cancel beats any mode).
//   Else if lid=0 and any mode: mode_1 -> SOAK, mode_2 -> WASH, mode_3 -> RINSE. Mode latched.
//   A mode with lid=1 is ignored.
//  Phase entry loads remaining = <PHASE>_CYCLES-1. So a phase lasts exactly <PHASE>_CYCLES unpaused clocks.
//  In SOAK/WASH/RINSE/SPIN:
//   - lid=1: remaining holds, paused=1, water_intake=0.
//   - lid=0: remaining decrements.
//   - remaining==0 with lid=0 advances: SOAK->WASH->RINSE.
//   - RINSE repeats until the latched pass count is reached (RINSE_REPEATS, or 1 for mode_3), reloading
//     RINSE_CYCLES-1 per pass; then -> SPIN.
//   - SPIN -> IDLE with done pulse.
//  water_intake=1 in SOAK/WASH/RINSE when lid=0 and remaining > <PHASE>_CYCLES-1-FILL_CYCLES.
//   Per rinse pass, fill repeats.
//  cancel in SOAK/WASH/RINSE -> SPIN next clock (drain+spin), remaining=SPIN_CYCLES-1, no refund.
//   SPIN then ends with done=0 (aborted). cancel in SPIN/IDLE is ignored.
//  coin=1 in any state other than IDLE -> coin_return pulse next clock, no state effect.
//   A coin and cancel together in READY give a single pulse.
//  Simultaneous events:
//   - cancel with remaining==0 -> SPIN via cancel.
//   - lid=1 with remaining==0 -> hold, no advance.
//  Reset mid-phase: abort immediately to IDLE, no coin_return, no done.
// TESTING
//  T1 reset; coin; mode_1,lid=0 -> SOAK 16, WASH 32, RINSE 16 x2, SPIN 8 clocks; done pulse at IDLE; water_intake 4 clk/pass.
//  T2 READY: cancel=1 together with mode_2=1 -> IDLE next clock, coin_return high exactly 1 clock, wash_operation never 1.
//  T3 WASH at remaining=20: lid=1 for 10 clocks -> remaining stays 20, paused=1; total WASH = 42 clocks.
//  T4 cancel in 2nd RINSE pass -> SPIN next clock with remaining=7; IDLE after 8 clocks; done stays 0.
//  T5 mode_3 -> single RINSE (16) then SPIN; coin=1 during RINSE -> one coin_return pulse, timing unchanged.
//  T6 reset_n low mid-SPIN, no clock edge -> idle=1, spin_operation=0, remaining=0 immediately.

Source files
------------

// File: rtl/wm_cycle_controller_if.sv
// Front-panel inputs and motor/valve/status outputs of one washing-machine controller.
interface wm_cycle_controller_if #(
  parameter int unsigned TIMER_W = 8
);
  logic               lid;
  logic               coin;
  logic               cancel;
  logic               mode_1;
  logic               mode_2;
  logic               mode_3;
  logic               idle;
  logic               ready;
  logic               soak_operation;
  logic               wash_operation;
  logic               rinse_operation;
  logic               spin_operation;
  logic               water_intake;
  logic               coin_return;
  logic               paused;
  logic               done;
  logic [TIMER_W-1:0] remaining;

  modport master (
    output lid, coin, cancel, mode_1, mode_2, mode_3,
    input  idle, ready, soak_operation, wash_operation, rinse_operation,
           spin_operation, water_intake, coin_return, paused, done, remaining
  );

  modport slave (
    input  lid, coin, cancel, mode_1, mode_2, mode_3,
    output idle, ready, soak_operation, wash_operation, rinse_operation,
           spin_operation, water_intake, coin_return, paused, done, remaining
  );
endinterface

// File: rtl/wm_cycle_controller.sv
// Coin-operated washing-machine sequencer: per-phase down-counter, lid pause,
// rinse repetition, mode-dependent entry, drain-on-cancel and change return.
module wm_cycle_controller #(
  parameter int unsigned TIMER_W       = 8,
  parameter int unsigned SOAK_CYCLES   = 16,
  parameter int unsigned WASH_CYCLES   = 32,
  parameter int unsigned RINSE_CYCLES  = 16,
  parameter int unsigned SPIN_CYCLES   = 8,
  parameter int unsigned FILL_CYCLES   = 4,
  parameter int unsigned RINSE_REPEATS = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  wm_cycle_controller_if.slave bus
);

  localparam int unsigned CNT_W = (RINSE_REPEATS > 1) ? $clog2(RINSE_REPEATS) : 1;

  localparam logic [TIMER_W-1:0] SOAK_LOAD  = TIMER_W'(SOAK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WASH_LOAD  = TIMER_W'(WASH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RINSE_LOAD = TIMER_W'(RINSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SPIN_LOAD  = TIMER_W'(SPIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RINSE_MORE = CNT_W'(RINSE_REPEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_SOAK, S_WASH, S_RINSE, S_SPIN
  } state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]   rinse_left_q, rinse_left_d;
  logic               aborted_q, aborted_d;
  logic               coin_ret_q, coin_ret_d;
  logic               done_q, done_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      rinse_left_q <= '0;
      aborted_q    <= 1'b0;
      coin_ret_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      rinse_left_q <= rinse_left_d;
      aborted_q    <= aborted_d;
      coin_ret_q   <= coin_ret_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    rinse_left_d = rinse_left_q;
    aborted_d    = aborted_q;
    coin_ret_d   = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.coin) state_d = S_READY;
      end
      S_READY: begin
        // cancel and coin in the same clock still refund only once
        coin_ret_d = bus.coin | bus.cancel;
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else if (!bus.lid) begin
          if (bus.mode_1) begin
            state_d   = S_SOAK;
            rem_d     = SOAK_LOAD;
            aborted_d = 1'b0;
          end else if (bus.mode_2) begin
            state_d   = S_WASH;
            rem_d     = WASH_LOAD;
            aborted_d = 1'b0;
          end else if (bus.mode_3) begin
            state_d      = S_RINSE;
            rem_d        = RINSE_LOAD;
            rinse_left_d = '0;
            aborted_d    = 1'b0;
          end
        end
      end
      S_SOAK, S_WASH, S_RINSE: begin
        coin_ret_d = bus.coin;
        if (bus.cancel) begin
          state_d   = S_SPIN;
          rem_d     = SPIN_LOAD;
          aborted_d = 1'b1;
        end else if (!bus.lid) begin
          if (rem_q != '0) begin
            rem_d = rem_q - TIMER_W'(1);
          end else if (state_q == S_SOAK) begin
            state_d = S_WASH;
            rem_d   = WASH_LOAD;
          end else if (state_q == S_WASH) begin
            state_d      = S_RINSE;
            rem_d        = RINSE_LOAD;
            rinse_left_d = RINSE_MORE;
          end else if (rinse_left_q != '0) begin
            rem_d        = RINSE_LOAD;
            rinse_left_d = rinse_left_q - CNT_W'(1);
          end else begin
            state_d = S_SPIN;
            rem_d   = SPIN_LOAD;
          end
        end
      end
      S_SPIN: begin
        coin_ret_d = bus.coin;
        if (!bus.lid) begin
          if (rem_q != '0) begin
            rem_d = rem_q - TIMER_W'(1);
          end else begin
            state_d      = S_IDLE;
            done_d       = !aborted_q;
            aborted_d    = 1'b0;
            rinse_left_d = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  logic phase_active;
  logic fill_soak, fill_wash, fill_rinse;

  // Fill while fewer than FILL_CYCLES unpaused clocks have elapsed in the pass.
  assign fill_soak  = (32'(rem_q) + FILL_CYCLES) >= SOAK_CYCLES;
  assign fill_wash  = (32'(rem_q) + FILL_CYCLES) >= WASH_CYCLES;
  assign fill_rinse = (32'(rem_q) + FILL_CYCLES) >= RINSE_CYCLES;

  assign phase_active = (state_q == S_SOAK) || (state_q == S_WASH) ||
                        (state_q == S_RINSE) || (state_q == S_SPIN);

  assign bus.idle            = (state_q == S_IDLE);
  assign bus.ready           = (state_q == S_READY);
  assign bus.soak_operation  = (state_q == S_SOAK);
  assign bus.wash_operation  = (state_q == S_WASH);
  assign bus.rinse_operation = (state_q == S_RINSE);
  assign bus.spin_operation  = (state_q == S_SPIN);
  assign bus.paused          = phase_active & bus.lid;
  assign bus.water_intake    = !bus.lid &&
                               (((state_q == S_SOAK)  && fill_soak) ||
                                ((state_q == S_WASH)  && fill_wash) ||
                                ((state_q == S_RINSE) && fill_rinse));
  assign bus.coin_return     = coin_ret_q;
  assign bus.done            = done_q;
  assign bus.remaining       = rem_q;

endmodule

// File: tb/tb_wm_cycle_controller.sv
// Bench for wm_cycle_controller: directed program scenarios plus random panel
// activity, compared each clock against a program-queue reference model.
module tb_wm_cycle_controller;

  localparam int TIMER_W       = 8;
  localparam int SOAK_CYCLES   = 16;
  localparam int WASH_CYCLES   = 32;
  localparam int RINSE_CYCLES  = 16;
  localparam int SPIN_CYCLES   = 8;
  localparam int FILL_CYCLES   = 4;
  localparam int RINSE_REPEATS = 2;

  localparam int P_IDLE  = 0;
  localparam int P_READY = 1;
  localparam int P_SOAK  = 2;
  localparam int P_WASH  = 3;
  localparam int P_RINSE = 4;
  localparam int P_SPIN  = 5;

  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  wm_cycle_controller_if #(.TIMER_W(TIMER_W)) bus ();

  wm_cycle_controller #(
    .TIMER_W      (TIMER_W),
    .SOAK_CYCLES  (SOAK_CYCLES),
    .WASH_CYCLES  (WASH_CYCLES),
    .RINSE_CYCLES (RINSE_CYCLES),
    .SPIN_CYCLES  (SPIN_CYCLES),
    .FILL_CYCLES  (FILL_CYCLES),
    .RINSE_REPEATS(RINSE_REPEATS)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: the program is a list of phases still to run; 'left'
  // counts unpaused clocks still owed to the phase at the head of the list.
  int m_ph;
  int m_left;
  int m_prog[$];
  bit m_aborted;
  bit m_cr;
  bit m_done;

  function automatic int plen(input int p);
    case (p)
      P_SOAK:  return SOAK_CYCLES;
      P_WASH:  return WASH_CYCLES;
      P_RINSE: return RINSE_CYCLES;
      P_SPIN:  return SPIN_CYCLES;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = P_IDLE; m_left = 0; m_prog.delete();
    m_aborted = 1'b0; m_cr = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_start(input int first, input int passes);
    m_prog.delete();
    if (first == P_SOAK) m_prog.push_back(P_SOAK);
    if (first != P_RINSE) m_prog.push_back(P_WASH);
    for (int i = 0; i < passes; i++) m_prog.push_back(P_RINSE);
    m_prog.push_back(P_SPIN);
    m_ph = m_prog[0];
    m_left = plen(m_ph);
    m_aborted = 1'b0;
  endtask

  task automatic model_step(input bit lid, coin, cancel, m1, m2, m3);
    m_cr = 1'b0;
    m_done = 1'b0;
    if (m_ph == P_IDLE) begin
      if (coin) m_ph = P_READY;
    end else if (m_ph == P_READY) begin
      m_cr = coin || cancel;
      if (cancel) m_ph = P_IDLE;
      else if (!lid && m1) model_start(P_SOAK, RINSE_REPEATS);
      else if (!lid && m2) model_start(P_WASH, RINSE_REPEATS);
      else if (!lid && m3) model_start(P_RINSE, 1);
    end else begin
      m_cr = coin;
      if (cancel && m_ph != P_SPIN) begin
        m_prog.delete();
        m_prog.push_back(P_SPIN);
        m_ph = P_SPIN;
        m_left = SPIN_CYCLES;
        m_aborted = 1'b1;
      end else if (!lid) begin
        if (m_left > 1) begin
          m_left--;
        end else begin
          void'(m_prog.pop_front());
          if (m_prog.size() == 0) begin
            m_ph = P_IDLE;
            m_left = 0;
            m_done = !m_aborted;
            m_aborted = 1'b0;
          end else begin
            m_ph = m_prog[0];
            m_left = plen(m_ph);
          end
        end
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [9:0] exp_v, got_v;
    bit water, in_phase;
    in_phase = (m_ph >= P_SOAK);
    water = (m_ph >= P_SOAK) && (m_ph <= P_RINSE) && !bus.lid &&
            ((plen(m_ph) - m_left) < FILL_CYCLES);
    exp_v = {m_ph == P_IDLE, m_ph == P_READY, m_ph == P_SOAK, m_ph == P_WASH,
             m_ph == P_RINSE, m_ph == P_SPIN, water, m_cr,
             in_phase && bus.lid, m_done};
    got_v = {bus.idle, bus.ready, bus.soak_operation, bus.wash_operation,
             bus.rinse_operation, bus.spin_operation, bus.water_intake,
             bus.coin_return, bus.paused, bus.done};
    check_eq({tag, "_outs"}, 32'(got_v), 32'(exp_v));
    check_eq({tag, "_remaining"}, 32'(bus.remaining), in_phase ? 32'(m_left - 1) : 32'd0);
  endtask

  // One clock: drive inputs, advance the model, sample just after the edge.
  task automatic cycle(input bit lid, coin, cancel, m1, m2, m3);
    bus.lid = lid; bus.coin = coin; bus.cancel = cancel;
    bus.mode_1 = m1; bus.mode_2 = m2; bus.mode_3 = m3;
    model_step(lid, coin, cancel, m1, m2, m3);
    @(posedge clock);
    #1;
    check_outputs("cyc");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.lid = 0; bus.coin = 0; bus.cancel = 0;
    bus.mode_1 = 0; bus.mode_2 = 0; bus.mode_3 = 0;
    model_reset();
    #12;
    check_outputs("reset");
    reset_n = 1'b1;
    #4;

    // Full mode_1 program
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    run(SOAK_CYCLES + WASH_CYCLES + 2 * RINSE_CYCLES + SPIN_CYCLES + 3);

    // Cancel beats mode_2 in READY
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 1, 0);
    run(3);

    // Lid pause in WASH at remaining=20
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    run(11);
    check_eq("t3_rem20", 32'(bus.remaining), 32'd20);
    repeat (10) cycle(1, 0, 0, 0, 0, 0);
    check_eq("t3_paused_rem", 32'(bus.remaining), 32'd20);
    run(21 + 2 * RINSE_CYCLES + SPIN_CYCLES + 3);

    // Cancel in second rinse pass
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    run(WASH_CYCLES + RINSE_CYCLES + 5);
    cycle(0, 0, 1, 0, 0, 0);
    check_eq("t4_spin_rem", 32'(bus.remaining), 32'(SPIN_CYCLES - 1));
    run(SPIN_CYCLES + 2);

    // mode_3 with coin during rinse
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    run(5);
    cycle(0, 1, 0, 0, 0, 0);
    run(10 + SPIN_CYCLES + 3);

    // Async reset mid-SPIN
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    run(RINSE_CYCLES + 3);
    check_eq("t6_in_spin", 32'(bus.spin_operation), 32'd1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("t6_async");
    #2;
    reset_n = 1'b1;

    // Random front-panel activity
    for (int i = 0; i < 3000; i++) begin
      bit l, c, x, m1, m2, m3;
      l  = ($urandom_range(0, 5) == 0);
      c  = ($urandom_range(0, 15) == 0);
      x  = ($urandom_range(0, 39) == 0);
      m1 = ($urandom_range(0, 2) == 0);
      m2 = ($urandom_range(0, 2) == 0);
      m3 = ($urandom_range(0, 2) == 0);
      cycle(l, c, x, m1, m2, m3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
